reg_file_wb_unit: RTL and testbench
===================================

Name: reg_file_wb_unit

Overview:
- Integer register file (x0-x31) that terminates the writeback path.
- Consumes the selected writeback word and destination index from the writeback stage and commits them to architectural state.
- Serves two registered source-operand read ports to the decode/execute boundary.
- Provides write-to-read bypass and keeps its outputs coherent while the pipeline is stalled.

Parameters:
- XLEN, 32, data width of every register and of all data ports.
- ADDR_W, 5, register index width; register count = 2**ADDR_W.

Ports:
- clk_in  input  1  pipeline clock; all state updates on rising edge.
- rst_in  input  1  synchronous reset, active-high.
- wr_en_in  input  1  writeback enable from the writeback stage.
- rd_addr_in  input  ADDR_W  destination register index.
- rd_data_in  input  XLEN  writeback data (output of the writeback select mux).
- stall_in  input  1  pipeline stall; freezes the read-port sampling.
- rs1_addr_in  input  ADDR_W  source-1 index.
- rs2_addr_in  input  ADDR_W  source-2 index.
- rs1_out  output  XLEN  registered source-1 operand.
- rs2_out  output  XLEN  registered source-2 operand.

Behaviour:
- Reset: while rst_in=1 at a rising edge, all registers clear to 0, rs1_out=rs2_out=0, and both latched read indices clear to 0. A write presented in the reset cycle is discarded. Reset mid-stall overrides all other activity.
- Commit: when wr_en_in=1 and rd_addr_in!=0, regs[rd_addr_in]<=rd_data_in at the edge. Writes ignore stall_in; a repeated write of the same value under stall is harmless.
- x0: always reads 0. A write to x0 is discarded and never bypassed.
- Read, not stalled (stall_in=0): at the edge, latch rsN_addr_in into the held index hN, and update rsN_out:
  - rd_data_in if wr_en_in=1, rd_addr_in==rsN_addr_in and rd_addr_in!=0;
  - otherwise regs[rsN_addr_in].
- Read latency: one cycle. A write and a read of the same register in the same cycle return the new data (write-first).
- Read, stalled (stall_in=1): rsN_addr_in is ignored and hN is held.
  - rsN_out holds its value, unless wr_en_in=1, rd_addr_in==hN and rd_addr_in!=0, in which case rsN_out<=rd_data_in.
  - This keeps a held operand coherent with a writeback that completes during the stall.
- Both ports are independent. rs1 and rs2 may alias each other and the destination; both then receive the same bypassed value.
- No other outputs; no combinational path from any input to rs1_out/rs2_out.

Test Plan:
- Reset then read: rst_in=1 for 1 cycle, then read x1/x2 -> rs1_out=rs2_out=0x00000000 one cycle later.
- Write then read:
  - Cycle0: write x5=0xDEADBEEF.
  - Cycle1: rs1_addr_in=5 -> cycle2 rs1_out=0xDEADBEEF.
  - Write x0=0x12345678 and read x0 -> 0.
- Same-cycle bypass: write x7=0xA5A5A5A5 with rs1_addr_in=rs2_addr_in=7 in the same cycle -> next cycle both outputs 0xA5A5A5A5 (old value 0 never seen).
- Stall coherence:
  - Latch rs2 index 9 (x9=0x1).
  - Assert stall_in 3 cycles and change rs2_addr_in to 3 -> rs2_out stays 0x1.
  - Write x9=0x2 during the stall -> rs2_out=0x2 next edge.
  - Deassert stall_in -> rs2_out=regs[3].
- Reset mid-stall: stall_in=1 with x4 written to 0xFF, assert rst_in with wr_en_in=1 to x4=0x77 -> outputs 0 and x4 reads 0 afterwards.
- Sweep: write x1..x31 with value=index*0x01010101, read all pairs -> exact match, x0=0.

Source files
------------

// File: rtl/reg_file_wb_unit.sv
// -----------------------------------------------------------------------------
// reg_file_wb_unit
//
// Integer register file (x0..x31) at the end of the writeback path. It commits
// the writeback word to architectural state and serves two registered
// source-operand read ports to the decode/execute boundary.
//
// Read ports are write-first: a writeback to the register being read in the
// same cycle is forwarded. While the pipeline is stalled, each port keeps the
// index it last sampled. A writeback that completes during the stall and
// targets that index still updates the held operand, so the operand stays
// coherent with architectural state.
//
// Ports
//   clk_in       in   1       pipeline clock, rising edge
//   rst_in       in   1       synchronous reset, active-high
//   wr_en_in     in   1       writeback enable
//   rd_addr_in   in   ADDR_W  writeback destination index
//   rd_data_in   in   XLEN    writeback data
//   stall_in     in   1       pipeline stall, freezes read-index sampling
//   rs1_addr_in  in   ADDR_W  source-1 index
//   rs2_addr_in  in   ADDR_W  source-2 index
//   rs1_out      out  XLEN    registered source-1 operand
//   rs2_out      out  XLEN    registered source-2 operand
// -----------------------------------------------------------------------------
module reg_file_wb_unit #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              wr_en_in,
    input  logic [ADDR_W-1:0] rd_addr_in,
    input  logic [XLEN-1:0]   rd_data_in,
    input  logic              stall_in,
    input  logic [ADDR_W-1:0] rs1_addr_in,
    input  logic [ADDR_W-1:0] rs2_addr_in,
    output logic [XLEN-1:0]   rs1_out,
    output logic [XLEN-1:0]   rs2_out
);

    localparam int NREG = 1 << ADDR_W;

    // Architectural state. Entry 0 is cleared by reset and never written.
    // Reads of x0 are also forced to zero, so x0 does not depend on the
    // reset having run.
    logic [XLEN-1:0]   regs_q [NREG];

    // Held read indices and registered operands.
    logic [ADDR_W-1:0] h1_q;
    logic [ADDR_W-1:0] h1_d;
    logic [ADDR_W-1:0] h2_q;
    logic [ADDR_W-1:0] h2_d;
    logic [XLEN-1:0]   rs1_q;
    logic [XLEN-1:0]   rs1_d;
    logic [XLEN-1:0]   rs2_q;
    logic [XLEN-1:0]   rs2_d;

    // Combinational helpers.
    logic              wr_hit_s;
    logic [XLEN-1:0]   rf_rd1_s;
    logic [XLEN-1:0]   rf_rd2_s;

    // Computes the next value of one read port.
    //   Not stalled: forward the writeback on an index match, otherwise read
    //                the array (write-first).
    //   Stalled:     hold the operand, unless the writeback targets the held
    //                index.
    // wr_hit already excludes x0, so x0 is never forwarded.
    function automatic logic [XLEN-1:0] port_next(
        input logic              stall,
        input logic              wr_hit,
        input logic [ADDR_W-1:0] wr_addr,
        input logic [XLEN-1:0]   wr_data,
        input logic [ADDR_W-1:0] req_addr,
        input logic [ADDR_W-1:0] held_addr,
        input logic [XLEN-1:0]   rf_val,
        input logic [XLEN-1:0]   cur_val
    );
        logic [XLEN-1:0] nxt;
        if (stall) begin
            if (wr_hit && (wr_addr == held_addr)) begin
                nxt = wr_data;
            end else begin
                nxt = cur_val;
            end
        end else begin
            if (wr_hit && (wr_addr == req_addr)) begin
                nxt = wr_data;
            end else begin
                nxt = rf_val;
            end
        end
        return nxt;
    endfunction

    // Qualifies the writeback: a write to x0 is dropped.
    always_comb begin
        wr_hit_s = wr_en_in && (rd_addr_in != {ADDR_W{1'b0}});
    end

    // Reads the array for both ports, with x0 hard-wired to zero.
    always_comb begin
        rf_rd1_s = {XLEN{1'b0}};
        rf_rd2_s = {XLEN{1'b0}};
        if (rs1_addr_in != {ADDR_W{1'b0}}) begin
            rf_rd1_s = regs_q[rs1_addr_in];
        end else begin
            rf_rd1_s = {XLEN{1'b0}};
        end
        if (rs2_addr_in != {ADDR_W{1'b0}}) begin
            rf_rd2_s = regs_q[rs2_addr_in];
        end else begin
            rf_rd2_s = {XLEN{1'b0}};
        end
    end

    // Computes next-state values for the held indices and the operands.
    always_comb begin
        h1_d  = h1_q;
        h2_d  = h2_q;
        rs1_d = rs1_q;
        rs2_d = rs2_q;
        if (stall_in) begin
            h1_d = h1_q;
            h2_d = h2_q;
        end else begin
            h1_d = rs1_addr_in;
            h2_d = rs2_addr_in;
        end
        rs1_d = port_next(stall_in, wr_hit_s, rd_addr_in, rd_data_in,
                          rs1_addr_in, h1_q, rf_rd1_s, rs1_q);
        rs2_d = port_next(stall_in, wr_hit_s, rd_addr_in, rd_data_in,
                          rs2_addr_in, h2_q, rf_rd2_s, rs2_q);
    end

    // Commits the writeback into the array. Stall does not block writes.
    // Reset clears everything and discards any write in the same cycle.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= {XLEN{1'b0}};
            end
        end else if (wr_hit_s) begin
            regs_q[rd_addr_in] <= rd_data_in;
        end else begin
            regs_q[rd_addr_in] <= regs_q[rd_addr_in];
        end
    end

    // Updates the held indices and registered operands.
    // Reset overrides stall and writeback.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            h1_q  <= {ADDR_W{1'b0}};
            h2_q  <= {ADDR_W{1'b0}};
            rs1_q <= {XLEN{1'b0}};
            rs2_q <= {XLEN{1'b0}};
        end else begin
            h1_q  <= h1_d;
            h2_q  <= h2_d;
            rs1_q <= rs1_d;
            rs2_q <= rs2_d;
        end
    end

    assign rs1_out = rs1_q;
    assign rs2_out = rs2_q;

endmodule

// File: tb/tb_reg_file_wb_unit.sv
// -----------------------------------------------------------------------------
// tb_reg_file_wb_unit
//
// Self-checking bench for reg_file_wb_unit. It runs in three phases:
//   1. a table of directed one-cycle vectors with constant expected outputs;
//   2. randomized traffic checked against a behavioural model;
//   3. a full sweep that writes every register and reads all index pairs.
// -----------------------------------------------------------------------------
module tb_reg_file_wb_unit;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        wr_en_in = 1'b0;
    logic [4:0]  rd_addr_in = 5'd0;
    logic [31:0] rd_data_in = 32'd0;
    logic        stall_in = 1'b0;
    logic [4:0]  rs1_addr_in = 5'd0;
    logic [4:0]  rs2_addr_in = 5'd0;
    logic [31:0] rs1_out;
    logic [31:0] rs2_out;

    int checks = 0;
    int errors = 0;

    reg_file_wb_unit #(.XLEN(32), .ADDR_W(5)) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .wr_en_in    (wr_en_in),
        .rd_addr_in  (rd_addr_in),
        .rd_data_in  (rd_data_in),
        .stall_in    (stall_in),
        .rs1_addr_in (rs1_addr_in),
        .rs2_addr_in (rs2_addr_in),
        .rs1_out     (rs1_out),
        .rs2_out     (rs2_out)
    );

    always #5 clk_in = ~clk_in;

    // Reference model, stated in terms of the behavioural rules rather than
    // the RTL structure.
    logic [31:0] m_regs [32];
    logic [4:0]  m_h1;
    logic [4:0]  m_h2;
    logic [31:0] m_o1;
    logic [31:0] m_o2;

    task automatic model_step(input logic rst, input logic we, input logic [4:0] wa,
                              input logic [31:0] wd, input logic stall,
                              input logic [4:0] a1, input logic [4:0] a2);
        logic wrote;
        if (rst) begin
            foreach (m_regs[k]) m_regs[k] = 32'd0;
            m_h1 = 5'd0; m_h2 = 5'd0; m_o1 = 32'd0; m_o2 = 32'd0;
        end else begin
            wrote = we && (wa != 5'd0);
            if (wrote) m_regs[wa] = wd;
            if (!stall) begin
                // Write-first: read the state as it stands after the commit.
                m_h1 = a1; m_h2 = a2;
                m_o1 = m_regs[a1];
                m_o2 = m_regs[a2];
            end else begin
                if (wrote && wa == m_h1) m_o1 = wd;
                if (wrote && wa == m_h2) m_o2 = wd;
            end
        end
    endtask

    // Drives one cycle of inputs, lets the edge pass, and advances the model.
    task automatic cycle(input logic rst, input logic we, input logic [4:0] wa,
                         input logic [31:0] wd, input logic stall,
                         input logic [4:0] a1, input logic [4:0] a2);
        rst_in = rst; wr_en_in = we; rd_addr_in = wa; rd_data_in = wd;
        stall_in = stall; rs1_addr_in = a1; rs2_addr_in = a2;
        @(posedge clk_in);
        #1;
        model_step(rst, we, wa, wd, stall, a1, a2);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        stall;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [31:0] e1;
        logic [31:0] e2;
    } vec_t;

    function automatic vec_t mkv(input logic rst, input logic we, input logic [4:0] wa,
                                 input logic [31:0] wd, input logic stall,
                                 input logic [4:0] a1, input logic [4:0] a2,
                                 input logic [31:0] e1, input logic [31:0] e2);
        vec_t v;
        v.rst = rst; v.we = we; v.wa = wa; v.wd = wd; v.stall = stall;
        v.a1 = a1; v.a2 = a2; v.e1 = e1; v.e2 = e2;
        return v;
    endfunction

    localparam int NVEC = 19;
    vec_t tbl [NVEC];

    initial begin
        //             rst   we    wa     wd            stall a1     a2     e1            e2
        tbl[0]  = mkv(1'b1, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd0, 32'h0,        32'h0);
        tbl[1]  = mkv(1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd1, 5'd2, 32'h0,        32'h0);
        tbl[2]  = mkv(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0, 32'h0,        32'h0);
        tbl[3]  = mkv(1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0);
        tbl[4]  = mkv(1'b0, 1'b1, 5'd0, 32'h12345678, 1'b0, 5'd0, 5'd0, 32'h0,        32'h0);
        tbl[5]  = mkv(1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd5, 32'h0,        32'hDEADBEEF);
        tbl[6]  = mkv(1'b0, 1'b1, 5'd7, 32'hA5A5A5A5, 1'b0, 5'd7, 5'd7, 32'hA5A5A5A5, 32'hA5A5A5A5);
        tbl[7]  = mkv(1'b0, 1'b1, 5'd3, 32'h00000033, 1'b0, 5'd3, 5'd3, 32'h00000033, 32'h00000033);
        tbl[8]  = mkv(1'b0, 1'b1, 5'd9, 32'h00000001, 1'b0, 5'd7, 5'd9, 32'hA5A5A5A5, 32'h00000001);
        tbl[9]  = mkv(1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 5'd3, 5'd3, 32'hA5A5A5A5, 32'h00000001);
        tbl[10] = mkv(1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 5'd3, 5'd3, 32'hA5A5A5A5, 32'h00000001);
        tbl[11] = mkv(1'b0, 1'b1, 5'd9, 32'h00000002, 1'b1, 5'd3, 5'd3, 32'hA5A5A5A5, 32'h00000002);
        tbl[12] = mkv(1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd7, 5'd3, 32'hA5A5A5A5, 32'h00000033);
        tbl[13] = mkv(1'b0, 1'b1, 5'd4, 32'h000000FF, 1'b0, 5'd4, 5'd4, 32'h000000FF, 32'h000000FF);
        tbl[14] = mkv(1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 5'd0, 32'h000000FF, 32'h000000FF);
        tbl[15] = mkv(1'b1, 1'b1, 5'd4, 32'h00000077, 1'b1, 5'd4, 5'd4, 32'h0,        32'h0);
        tbl[16] = mkv(1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd4, 5'd9, 32'h0,        32'h0);
        tbl[17] = mkv(1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd0, 32'h0,        32'h0);
        tbl[18] = mkv(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd1, 5'd1, 32'h0,        32'h0);

        // Phase 1: directed vectors.
        for (int i = 0; i < NVEC; i++) begin
            cycle(tbl[i].rst, tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].stall, tbl[i].a1, tbl[i].a2);
            check($sformatf("vec%0d_rs1", i), rs1_out, tbl[i].e1);
            check($sformatf("vec%0d_rs2", i), rs2_out, tbl[i].e2);
        end

        // Phase 2: randomized traffic. Indices are biased to a few registers
        // so that bypass and stall hits occur often.
        for (int n = 0; n < 800; n++) begin
            logic        r_rst;
            logic        r_we;
            logic        r_st;
            logic [4:0]  r_wa;
            logic [4:0]  r_a1;
            logic [4:0]  r_a2;
            logic [31:0] r_wd;
            r_rst = ($urandom_range(0, 63) == 0);
            r_we  = ($urandom_range(0, 2) != 0);
            r_st  = ($urandom_range(0, 2) == 0);
            r_wa  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
            r_a1  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
            r_a2  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
            r_wd  = $urandom;
            cycle(r_rst, r_we, r_wa, r_wd, r_st, r_a1, r_a2);
            check("rand_rs1", rs1_out, m_o1);
            check("rand_rs2", rs2_out, m_o2);
        end

        // Phase 3: write x1..x31 with index*0x01010101, then read every pair.
        // A write to x0 is attempted too and must not stick.
        cycle(1'b0, 1'b1, 5'd0, 32'hCAFEF00D, 1'b0, 5'd0, 5'd0);
        for (int i = 1; i < 32; i++) begin
            cycle(1'b0, 1'b1, 5'(i), 32'(i) * 32'h01010101, 1'b0, 5'd0, 5'd0);
        end
        for (int a = 0; a < 32; a++) begin
            for (int b = 0; b < 32; b++) begin
                cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'(a), 5'(b));
                check("sweep_rs1", rs1_out, 32'(a) * 32'h01010101);
                check("sweep_rs2", rs2_out, 32'(b) * 32'h01010101);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
